// File: rtl/jtopl_eg_mc.sv
// -----------------------------------------------------------------------------
// jtopl_eg_mc
// Time-multiplexed multi-slot ADSR envelope generator.
//
// An internal slot counter walks slots 0..SLOTS-1, one slot per cenop strobe.
// For the slot on 'slot' the register bank presents that slot's configuration.
// On the same clock edge the slot's phase, level and previous key-on are read,
// updated and written back, and the registered outputs (eg, eg_slot, pg_rst)
// are loaded for that slot.
//
// Strobe semantics: cenop is a qualifier, not a handshake. A cycle with
// cenop=1 consumes the configuration for 'slot' and advances everything.
// A cycle with cenop=0 changes nothing; all outputs hold.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   cenop             operator-rate clock enable
//   eg_stop           freezes the global envelope counter
//   slot, zero        slot being served this cycle, high when slot==0
//   keyon..tl         per-slot configuration for 'slot'
//   eg, eg_slot       registered attenuation and the slot it belongs to
//   pg_rst            one-cycle phase-reset pulse for eg_slot (key-on edge)
//   dbg_phase         envelope phase written back for eg_slot
//                     (0=ATTACK 1=DECAY 2=SUSTAIN 3=RELEASE)
// -----------------------------------------------------------------------------
module jtopl_eg_mc #(
  parameter  int SLOTS = 18,
  parameter  int EGW   = 10,
  parameter  int CNTW  = 15,
  localparam int SW    = $clog2(SLOTS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cenop,
  input  logic           eg_stop,
  output logic [SW-1:0]  slot,
  output logic           zero,
  input  logic           keyon,
  input  logic           en_sus,
  input  logic [3:0]     arate,
  input  logic [3:0]     drate,
  input  logic [3:0]     rrate,
  input  logic [3:0]     sl,
  input  logic           ksr,
  input  logic [3:0]     keycode,
  input  logic [5:0]     tl,
  output logic [EGW-1:0] eg,
  output logic [SW-1:0]  eg_slot,
  output logic           pg_rst,
  output logic [1:0]     dbg_phase
);

  localparam logic [EGW-1:0] EG_MAX    = '1;
  localparam logic [SW-1:0]  SLOT_LAST = SW'(SLOTS - 1);

  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY   = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } phase_e;

  // Global state
  logic [SW-1:0]   slot_q, slot_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Per-slot state
  phase_e          phase_q [SLOTS];
  logic [EGW-1:0]  level_q [SLOTS];
  logic            kon_q   [SLOTS];
  phase_e          phase_d;
  logic [EGW-1:0]  level_d;
  logic            kon_d;

  // Registered outputs
  logic [EGW-1:0]  eg_q, eg_d;
  logic [SW-1:0]   eg_slot_q, eg_slot_d;
  logic            pg_rst_q, pg_rst_d;
  phase_e          dbg_phase_q;

  // Current slot read-out
  phase_e          cur_phase;
  logic [EGW-1:0]  cur_level;
  logic            cur_kon;

  assign cur_phase = phase_q[slot_q];
  assign cur_level = level_q[slot_q];
  assign cur_kon   = kon_q[slot_q];

  // Update datapath
  logic            key_edge;
  phase_e          phase_k;
  logic [3:0]      rate4;
  logic [3:0]      ks;
  logic [6:0]      rsum;
  logic [5:0]      rate;
  logic [3:0]      hi;
  logic [1:0]      amt_sh;
  logic            step;
  logic [EGW+3:0]  dec_base;
  logic [EGW+3:0]  dec;
  logic [EGW:0]    inc;
  logic            reached;
  logic [EGW:0]    tl_sc;
  logic [EGW:0]    eg_sum;

  // Total level scaled so that its 7-bit range maps onto the EGW-bit level.
  if (EGW >= 7) begin : g_tl_up
    assign tl_sc = (EGW+1)'(tl) << (EGW - 7);
  end else begin : g_tl_dn
    assign tl_sc = (EGW+1)'(tl >> (7 - EGW));
  end

  always_comb begin
    kon_d    = keyon;
    pg_rst_d = 1'b0;
    key_edge = 1'b0;
    phase_k  = cur_phase;

    // Key edges override the stored phase; later transitions in this same
    // visit are suppressed so the edge always wins.
    if (keyon && !cur_kon) begin
      phase_k  = ATTACK;
      pg_rst_d = 1'b1;
      key_edge = 1'b1;
    end else if (!keyon && cur_kon) begin
      phase_k  = RELEASE;
      key_edge = 1'b1;
    end

    case (phase_k)
      ATTACK:  rate4 = arate;
      DECAY:   rate4 = drate;
      RELEASE: rate4 = rrate;
      default: rate4 = 4'd0;
    endcase

    ks   = ksr ? keycode : {2'b00, keycode[3:2]};
    rsum = {1'b0, rate4, 2'b00} + {3'b000, ks};
    if (rate4 == 4'd0)      rate = 6'd0;
    else if (rsum > 7'd63)  rate = 6'd63;
    else                    rate = rsum[5:0];
    hi = rate[5:2];

    // Slow rates step when the low (12-hi) counter bits are all zero;
    // fast rates step on every visit with a power-of-two amount.
    step   = 1'b0;
    amt_sh = 2'd0;
    if (rate4 != 4'd0) begin
      if (hi < 4'd12) begin
        step = (cnt_q[11:0] & (12'hfff >> hi)) == 12'd0;
      end else begin
        step   = 1'b1;
        amt_sh = 2'(hi - 4'd12);
      end
    end

    dec_base = (EGW+4)'(cur_level >> 3) + (EGW+4)'(1);
    dec      = dec_base << amt_sh;
    inc      = {1'b0, cur_level} + ((EGW+1)'(1) << amt_sh);

    level_d = cur_level;
    phase_d = phase_k;
    reached = 1'b0;

    case (phase_k)
      ATTACK: begin
        if (rate4 != 4'd0) begin
          if (hi == 4'd15) begin
            level_d = '0;
          end else if (step) begin
            level_d = (dec >= {4'b0000, cur_level}) ? '0 : cur_level - dec[EGW-1:0];
          end
        end
        if (!key_edge && level_d == '0) phase_d = DECAY;
      end
      DECAY: begin
        if (step) level_d = inc[EGW] ? EG_MAX : inc[EGW-1:0];
        // sl==15 means the sustain point is full attenuation.
        reached = (sl == 4'd15) ? (level_d == EG_MAX)
                                : (level_d[EGW-1:EGW-4] >= sl);
        if (!key_edge && reached) phase_d = en_sus ? SUSTAIN : RELEASE;
      end
      RELEASE: begin
        if (step) level_d = inc[EGW] ? EG_MAX : inc[EGW-1:0];
      end
      default: ;
    endcase

    eg_sum    = {1'b0, level_d} + tl_sc;
    eg_d      = eg_sum[EGW] ? EG_MAX : eg_sum[EGW-1:0];
    eg_slot_d = slot_q;

    slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
    cnt_d  = cnt_q;
    if (slot_q == SLOT_LAST && !eg_stop) cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q      <= '0;
      cnt_q       <= '0;
      eg_q        <= EG_MAX;
      eg_slot_q   <= '0;
      pg_rst_q    <= 1'b0;
      dbg_phase_q <= RELEASE;
      for (int i = 0; i < SLOTS; i++) begin
        phase_q[i] <= RELEASE;
        level_q[i] <= EG_MAX;
        kon_q[i]   <= 1'b0;
      end
    end else if (cenop) begin
      slot_q          <= slot_d;
      cnt_q           <= cnt_d;
      eg_q            <= eg_d;
      eg_slot_q       <= eg_slot_d;
      pg_rst_q        <= pg_rst_d;
      dbg_phase_q     <= phase_d;
      phase_q[slot_q] <= phase_d;
      level_q[slot_q] <= level_d;
      kon_q[slot_q]   <= kon_d;
    end
  end

  assign slot      = slot_q;
  assign zero      = (slot_q == '0);
  assign eg        = eg_q;
  assign eg_slot   = eg_slot_q;
  assign pg_rst    = pg_rst_q;
  assign dbg_phase = dbg_phase_q;

endmodule

// File: tb/tb_jtopl_eg_mc.sv
// -----------------------------------------------------------------------------
// Bench for jtopl_eg_mc. Slot 3 of an 18-slot instance carries the envelope
// under test; every other slot is kept idle and must read full attenuation.
// A 4-slot instance shares the inputs and is used for slot wrap / zero.
// -----------------------------------------------------------------------------
module tb_jtopl_eg_mc;

  localparam int SLOTS = 18;
  localparam int EGW   = 10;
  localparam int SW    = 5;
  localparam int TS    = 3;
  localparam int EXPW  = SW + EGW + 3;
  localparam logic [EGW-1:0] MAXL = 10'd1023;
  localparam logic [1:0] PH_A = 2'd0, PH_D = 2'd1, PH_S = 2'd2, PH_R = 2'd3;

  typedef struct {
    logic       kon;
    logic       es;
    logic [3:0] ar, dr, rr, sl;
    logic       ksr;
    logic [3:0] kc;
    logic [5:0] tl;
  } cfg_t;

  typedef struct {
    cfg_t           c;
    logic [EGW-1:0] eg;
    logic           pg;
    logic [1:0]     ph;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, cenop, eg_stop, keyon, en_sus, ksr;
  logic [3:0] arate, drate, rrate, sl, keycode;
  logic [5:0] tl;
  logic [SW-1:0]  slot, eg_slot;
  logic           zero, pg_rst;
  logic [EGW-1:0] eg;
  logic [1:0]     dbg_phase;
  logic [1:0]     slot4, eg_slot4;
  logic           zero4, pg4;
  logic [EGW-1:0] eg4;
  logic [1:0]     ph4;

  always #5 clk = ~clk;

  jtopl_eg_mc #(.SLOTS(SLOTS), .EGW(EGW), .CNTW(15)) dut (
    .clk(clk), .rst(rst), .cenop(cenop), .eg_stop(eg_stop),
    .slot(slot), .zero(zero), .keyon(keyon), .en_sus(en_sus),
    .arate(arate), .drate(drate), .rrate(rrate), .sl(sl), .ksr(ksr),
    .keycode(keycode), .tl(tl), .eg(eg), .eg_slot(eg_slot),
    .pg_rst(pg_rst), .dbg_phase(dbg_phase)
  );

  jtopl_eg_mc #(.SLOTS(4), .EGW(EGW), .CNTW(15)) dut4 (
    .clk(clk), .rst(rst), .cenop(cenop), .eg_stop(eg_stop),
    .slot(slot4), .zero(zero4), .keyon(keyon), .en_sus(en_sus),
    .arate(arate), .drate(drate), .rrate(rrate), .sl(sl), .ksr(ksr),
    .keycode(keycode), .tl(tl), .eg(eg4), .eg_slot(eg_slot4),
    .pg_rst(pg4), .dbg_phase(ph4)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [EXPW-1:0] exp_q[$];
  logic [EXPW-1:0] last_exp;
  int   ms, ms4, cnt_m;
  logic g_stop;
  cfg_t idle_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic cfg_t mk(input logic kon, input logic es, input logic [3:0] ar,
                              input logic [3:0] dr, input logic [3:0] rr,
                              input logic [3:0] s, input logic k,
                              input logic [3:0] kc, input logic [5:0] t);
    cfg_t c;
    c.kon = kon; c.es = es; c.ar = ar; c.dr = dr; c.rr = rr;
    c.sl = s; c.ksr = k; c.kc = kc; c.tl = t;
    return c;
  endfunction

  function automatic logic [EXPW-1:0] pack(input int s, input logic [EGW-1:0] e,
                                           input logic p, input logic [1:0] ph);
    return {SW'(s), e, p, ph};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input cfg_t c);
    keyon = c.kon; en_sus = c.es; arate = c.ar; drate = c.dr; rrate = c.rr;
    sl = c.sl; ksr = c.ksr; keycode = c.kc; tl = c.tl;
  endtask

  task automatic check_out(input logic [EXPW-1:0] e);
    chk("eg_slot", eg_slot, e[EXPW-1 -: SW]);
    chk("eg", eg, e[EGW+2 -: EGW]);
    chk("pg_rst", pg_rst, e[2]);
    chk("phase", dbg_phase, e[1:0]);
  endtask

  // One cenop cycle: present config for the modelled slot, expect output.
  task automatic run_cycle(input cfg_t c, input logic [EXPW-1:0] e);
    drive(c);
    eg_stop = g_stop;
    cenop   = 1'b1;
    exp_q.push_back(e);
    if (ms == SLOTS - 1 && !g_stop) cnt_m = (cnt_m + 1) % 32768;
    ms  = (ms + 1) % SLOTS;
    ms4 = (ms4 + 1) % 4;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 1, 0);
    end else begin
      last_exp = exp_q.pop_front();
      check_out(last_exp);
    end
    chk("slot", slot, ms);
    chk("zero", zero, ms == 0);
    chk("slot4", slot4, ms4);
    chk("zero4", zero4, ms4 == 0);
  endtask

  task automatic hold_cycle();
    cenop = 1'b0;
    @(posedge clk);
    #1;
    check_out(last_exp);
    chk("hold_slot", slot, ms);
    chk("hold_slot4", slot4, ms4);
  endtask

  // Idle slots are never keyed, so they always read full attenuation.
  task automatic goto_ts();
    for (int i = 0; i < SLOTS && ms != TS; i++)
      run_cycle(idle_c, pack(ms, MAXL, 1'b0, PH_R));
  endtask

  task automatic visit(input cfg_t c, input logic [EGW-1:0] e_eg,
                       input logic e_pg, input logic [1:0] e_ph);
    goto_ts();
    run_cycle(c, pack(TS, e_eg, e_pg, e_ph));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_eg"}, eg, MAXL);
    chk({tag, "_pg"}, pg_rst, 0);
    chk({tag, "_slot"}, slot, 0);
    chk({tag, "_zero"}, zero, 1);
    chk({tag, "_eg_slot"}, eg_slot, 0);
    chk({tag, "_phase"}, dbg_phase, PH_R);
    chk({tag, "_slot4"}, slot4, 0);
    chk({tag, "_eg4"}, eg4, MAXL);
    chk({tag, "_eg_slot4"}, eg_slot4, 0);
    chk({tag, "_pg4"}, pg4, 0);
    chk({tag, "_ph4"}, ph4, PH_R);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    vec_t tbl[9];
    cfg_t base, c;
    int   lvl;

    idle_c = mk(1'b0, 1'b0, 4'd15, 4'd15, 4'd15, 4'd0, 1'b0, 4'd0, 6'd0);
    base   = mk(1'b1, 1'b1, 4'd15, 4'd15, 4'd15, 4'd4, 1'b0, 4'd0, 6'd0);

    // Instant attack, then decay with assorted rate scalings and TL.
    tbl[0] = '{base, 10'd0, 1'b1, PH_A};
    tbl[1] = '{base, 10'd0, 1'b0, PH_D};
    tbl[2] = '{base, 10'd8, 1'b0, PH_D};
    c = base; c.tl = 6'd5;
    tbl[3] = '{c, 10'd56, 1'b0, PH_D};            // 16 + 5*8
    c = base; c.ksr = 1'b1; c.kc = 4'd15;
    tbl[4] = '{c, 10'd24, 1'b0, PH_D};            // R saturates at 63: +8
    c = base; c.dr = 4'd13; c.ksr = 1'b1; c.kc = 4'd4;
    tbl[5] = '{c, 10'd28, 1'b0, PH_D};            // R=56, hi=14: +4
    c = base; c.dr = 4'd13; c.kc = 4'd15;
    tbl[6] = '{c, 10'd30, 1'b0, PH_D};            // R=55, hi=13: +2
    c = base; c.dr = 4'd0;
    tbl[7] = '{c, 10'd30, 1'b0, PH_D};            // rate 0: hold
    c = base; c.dr = 4'd12;
    tbl[8] = '{c, 10'd31, 1'b0, PH_D};            // R=48, hi=12: +1

    rst = 1'b0; cenop = 1'b0; g_stop = 1'b0; eg_stop = 1'b0;
    drive(idle_c);
    ms = 0; ms4 = 0; cnt_m = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    last_exp = pack(0, MAXL, 1'b0, PH_R);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) visit(tbl[i].c, tbl[i].eg, tbl[i].pg, tbl[i].ph);

    // Decay to sustain: first level with top nibble >= 4 is 263.
    for (int k = 1; k <= 29; k++)
      visit(base, 10'(31 + 8 * k), 1'b0, (k == 29) ? PH_S : PH_D);
    visit(base, 10'd263, 1'b0, PH_S);
    visit(base, 10'd263, 1'b0, PH_S);
    c = base; c.tl = 6'd63;
    visit(c, 10'd767, 1'b0, PH_S);                // 263 + 504, no clamp

    // Key-off: release at rr=15.
    c = base; c.kon = 1'b0;
    visit(c, 10'd271, 1'b0, PH_R);

    // Exponential attack at arate=13 (hi=13, amount 2), then instant.
    c = base; c.ar = 4'd13;
    visit(c, 10'd203, 1'b1, PH_A);
    visit(c, 10'd151, 1'b0, PH_A);
    visit(c, 10'd113, 1'b0, PH_A);
    c = base; c.es = 1'b0;
    visit(c, 10'd0, 1'b0, PH_D);

    // Percussive: no sustain, decay hands over to release at 256.
    for (int k = 1; k <= 32; k++)
      visit(c, 10'(8 * k), 1'b0, (k == 32) ? PH_R : PH_D);
    for (int j = 1; j <= 100; j++)
      visit(c, ((256 + 8 * j) > 1023) ? MAXL : 10'(256 + 8 * j), 1'b0, PH_R);
    c.tl = 6'd10;
    visit(c, MAXL, 1'b0, PH_R);                   // TL clamp

    // Key-off, re-key, then slow release at rr=4 (step every 256 frames).
    c = base; c.kon = 1'b0;
    visit(c, MAXL, 1'b0, PH_R);
    visit(base, 10'd0, 1'b1, PH_A);
    c = base; c.kon = 1'b0; c.rr = 4'd4;
    lvl = 0;
    goto_ts();
    if ((cnt_m & 255) == 0) lvl++;
    visit(c, 10'(lvl), 1'b0, PH_R);
    for (int v = 0; v < 300 && lvl < 1; v++) begin
      goto_ts();
      if ((cnt_m & 255) == 0) lvl++;
      visit(c, 10'(lvl), 1'b0, PH_R);
    end
    if (lvl < 1) chk("release_step_timeout", lvl, 1);
    goto_ts();
    if ((cnt_m & 255) == 0) lvl++;
    visit(c, 10'(lvl), 1'b0, PH_R);

    // Frozen counter off a step boundary: slow rate must not move.
    g_stop = 1'b1;
    for (int v = 0; v < 4; v++) begin
      goto_ts();
      if ((cnt_m & 255) == 0) lvl++;
      visit(c, 10'(lvl), 1'b0, PH_R);
    end
    // Fast rates still step with the counter frozen.
    c.rr = 4'd15;
    lvl = lvl + 8;
    visit(c, 10'(lvl), 1'b0, PH_R);
    g_stop = 1'b0;

    // cenop low: everything holds.
    repeat (3) hold_cycle();

    // Mid-sequence asynchronous reset.
    #2;
    cenop = 1'b1;
    rst   = 1'b0;
    #1;
    reset_checks("async_reset");
    @(posedge clk);
    #1;
    reset_checks("held_reset");
    rst = 1'b1;
    ms = 0; ms4 = 0; cnt_m = 0;
    exp_q.delete();
    for (int i = 0; i < SLOTS; i++)
      run_cycle(idle_c, pack(ms, MAXL, 1'b0, PH_R));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtopl_eg_mc.md
Name: jtopl_eg_mc

Overview:
- Parametrised, time-multiplexed multi-slot ADSR envelope generator; next generation of jtopl_eg.
- Slot count, level width and counter width are generics; slot sequencing is internal.
- Per-slot state (phase, level, previous key-on) lives in internal arrays.
- Sits between the register bank (supplies per-slot config for the slot index it drives) and the operator/phase generator (consumes attenuation and phase-reset pulse).

Parameters:
SLOTS, 18, number of time-multiplexed slots (2..64)
EGW, 10, envelope level width in bits; max attenuation = 2^EGW-1
CNTW, 15, global envelope counter width (>=12)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
cenop  in  1  operator-rate clock enable; all state advances only when high
eg_stop  in  1  freezes global envelope counter
slot  out  $clog2(SLOTS)  slot index whose config must be presented this cycle
zero  out  1  high while slot==0
keyon  in  1  key-on for current slot
en_sus  in  1  sustain enable for current slot
arate  in  4  attack rate
drate  in  4  decay rate
rrate  in  4  release rate
sl  in  4  sustain level
ksr  in  1  key-scale-rate select
keycode  in  4  key code for rate scaling
tl  in  6  total level
eg  out  EGW  attenuation for eg_slot, registered
eg_slot  out  $clog2(SLOTS)  slot index qualifying eg
pg_rst  out  1  one-cycle phase-reset pulse for eg_slot

Behaviour:
- Reset (rst low, async): slot=0, counter=0, eg=2^EGW-1, eg_slot=0, pg_rst=0; every slot phase=RELEASE, level=2^EGW-1, prev_keyon=0.
- Slot counter: increments on cenop, wraps SLOTS-1 -> 0.
- Global counter: increments (mod 2^CNTW) on cenop when slot==SLOTS-1 and eg_stop=0.
- Per cenop, the current slot is read, updated and written back. Registered outputs (eg, eg_slot, pg_rst) update on the same edge: latency 1 clock from slot presentation. Outputs hold when cenop=0.
- Phases: ATTACK, DECAY, SUSTAIN, RELEASE (2-bit).
- Key edges:
  - keyon=1, prev_keyon=0: phase=ATTACK, pg_rst=1.
  - keyon=0, prev_keyon=1: phase=RELEASE.
  - A key edge has priority over any same-cycle phase transition; the level update still applies using the new phase's rate.
- Rate select: rate4 = arate / drate / rrate by phase; SUSTAIN uses no rate (level held).
- Effective rate:
  - R = {rate4,2'b00} + (ksr ? keycode : keycode>>2), saturated at 63.
  - rate4==0 means R=0: no change.
  - hi = R[5:2].
- Step timing and size:
  - hi<12: step when counter[11-hi:0]==0, amount=1.
  - hi>=12: step every visit, amount = 1<<(hi-12).
- ATTACK:
  - hi==15: level=0 immediately.
  - Otherwise on step: level -= ((level>>3)+1)*amount, floored at 0.
  - level==0 after update: phase=DECAY.
- DECAY:
  - On step: level += amount, saturating.
  - When level[EGW-1:EGW-4] >= sl (sl==15 treated as full scale): phase = en_sus ? SUSTAIN : RELEASE.
- RELEASE: on step, level += amount, saturating at 2^EGW-1.
- eg_stop=1: counter frozen. Rates with hi>=12 still step; hi<12 steps only if the frozen counter matches.
- Output: eg = min(level + (tl << (EGW-7)), 2^EGW-1).
  - EGW<7: tl >> (7-EGW).
  - Sum computed at EGW+1 bits before clamping.
- Any mid-operation reset returns all state to reset values within the same clock.

Test Plan:
- Reset: hold rst=0 mid-sequence -> eg=1023, pg_rst=0, slot=0; after release, every slot reads eg=1023 with tl=0.
- Instant attack: slot 3, arate=15, ksr=0, keycode=0, tl=0, keyon rising -> pg_rst=1 with eg_slot=3, eg=0 in the same output; next visit phase=DECAY.
- Decay to sustain: drate=15, sl=4, en_sus=1 -> level climbs by 8 per visit, stops at first value with top 4 bits >=4 (>=256); eg stays constant while keyon held.
- Percussive: same as above with en_sus=0 -> after reaching 256, level keeps rising at rrate=15 to 1023 and saturates.
- Key-off release: rrate=4, ksr=0, keycode=0 (R=16, hi=4) -> level +1 only when counter[7:0]==0, i.e. every 256 frames; eg_stop=1 with counter[7:0]!=0 -> no change.
- TL clamp: level=1000, tl=10 -> eg=1023 (1000+80 clamped); SLOTS=4 build: slot wraps 3->0 and zero pulses every 4 cenop.
